// File: rtl/ahb_lite_slave_mux.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_slave_mux
// Description : AHB-Lite address decoder and data-phase response multiplexer
//               with an integrated default slave that answers transfers to
//               unmapped space with a two-cycle ERROR response.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_slave_mux #(
    parameter logic [7:0] S0_BASE = 8'h00,
    parameter logic [7:0] S1_BASE = 8'h20,
    parameter logic [7:0] S2_BASE = 8'h40,
    parameter logic [7:0] S3_BASE = 8'h48
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    output logic        HSEL_S0,
    output logic        HSEL_S1,
    output logic        HSEL_S2,
    output logic        HSEL_S3,
    input  logic [31:0] HRDATA_S0,
    input  logic [31:0] HRDATA_S1,
    input  logic [31:0] HRDATA_S2,
    input  logic [31:0] HRDATA_S3,
    input  logic        HREADYOUT_S0,
    input  logic        HREADYOUT_S1,
    input  logic        HREADYOUT_S2,
    input  logic        HREADYOUT_S3,
    input  logic        HRESP_S0,
    input  logic        HRESP_S1,
    input  logic        HRESP_S2,
    input  logic        HRESP_S3,
    output logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HRESP
);

    // One-hot record of which responder owns the current data phase
    typedef enum logic [5:0] {
        DP_NONE = 6'b000001,
        DP_S0   = 6'b000010,
        DP_S1   = 6'b000100,
        DP_S2   = 6'b001000,
        DP_S3   = 6'b010000,
        DP_DFLT = 6'b100000
    } dp_sel_t;

    // Default-slave error sequencer
    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    logic [3:0] w_hsel;
    logic       w_addr_dflt;
    logic       w_active;
    logic       w_unused;
    dp_sel_t    r_dp_sel;
    dp_sel_t    w_dp_next;
    ds_state_t  r_ds_state;
    ds_state_t  w_ds_next;
    logic       w_ds_hready;
    logic       w_ds_hresp;

    // Address decode; lower-numbered slaves win if two bases ever collide
    assign w_hsel[0]   = (HADDR[31:24] == S0_BASE);
    assign w_hsel[1]   = (HADDR[31:24] == S1_BASE) & ~w_hsel[0];
    assign w_hsel[2]   = (HADDR[31:24] == S2_BASE) & ~|w_hsel[1:0];
    assign w_hsel[3]   = (HADDR[31:24] == S3_BASE) & ~|w_hsel[2:0];
    assign w_addr_dflt = ~|w_hsel;
    assign w_active    = HTRANS[1];

    assign HSEL_S0 = w_hsel[0];
    assign HSEL_S1 = w_hsel[1];
    assign HSEL_S2 = w_hsel[2];
    assign HSEL_S3 = w_hsel[3];

    // Only the top address byte and the NONSEQ/SEQ bit of HTRANS matter here
    assign w_unused = &{1'b0, HADDR[23:0], HTRANS[0]};

    // Next data-phase owner, captured only when the bus accepts an address phase
    always_comb begin
        w_dp_next = r_dp_sel;
        if (HREADY) begin
            if (!w_active)      w_dp_next = DP_NONE;
            else if (w_hsel[0]) w_dp_next = DP_S0;
            else if (w_hsel[1]) w_dp_next = DP_S1;
            else if (w_hsel[2]) w_dp_next = DP_S2;
            else if (w_hsel[3]) w_dp_next = DP_S3;
            else                w_dp_next = DP_DFLT;
        end
    end

    // Data-phase owner register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_dp_sel <= DP_NONE;
        else          r_dp_sel <= w_dp_next;
    end

    // Default-slave state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_ds_state <= DS_IDLE;
        else          r_ds_state <= w_ds_next;
    end

    // Default-slave next state and its ready/response
    always_comb begin
        w_ds_next   = r_ds_state;
        w_ds_hready = 1'b1;
        w_ds_hresp  = 1'b0;
        unique case (r_ds_state)
            DS_IDLE: begin
                if (HREADY && w_active && w_addr_dflt) w_ds_next = DS_ERR1;
            end
            DS_ERR1: begin
                w_ds_hready = 1'b0;
                w_ds_hresp  = 1'b1;
                w_ds_next   = DS_ERR2;
            end
            DS_ERR2: begin
                w_ds_hresp = 1'b1;
                // HREADY is high here, so the next address phase is taken now
                if (w_active && w_addr_dflt) w_ds_next = DS_ERR1;
                else                         w_ds_next = DS_IDLE;
            end
            default: begin
                w_ds_next = DS_IDLE;
            end
        endcase
    end

    // Response mux steered by the registered data-phase owner
    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = 32'h0;
        unique case (r_dp_sel)
            DP_S0: begin
                HREADY = HREADYOUT_S0;
                HRESP  = HRESP_S0;
                HRDATA = HRDATA_S0;
            end
            DP_S1: begin
                HREADY = HREADYOUT_S1;
                HRESP  = HRESP_S1;
                HRDATA = HRDATA_S1;
            end
            DP_S2: begin
                HREADY = HREADYOUT_S2;
                HRESP  = HRESP_S2;
                HRDATA = HRDATA_S2;
            end
            DP_S3: begin
                HREADY = HREADYOUT_S3;
                HRESP  = HRESP_S3;
                HRDATA = HRDATA_S3;
            end
            DP_DFLT: begin
                HREADY = w_ds_hready;
                HRESP  = w_ds_hresp;
            end
            default: begin
                HREADY = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire
